// File: rtl/service_protocol_receiver.sv
`default_nettype none
// ============================================================================
// Module      : service_protocol_receiver
// Description : Receive side of the service protocol. Pops 16-bit words from
//               the SPI RX word FIFO, parses HEAD1, HEAD2, SIZE data words,
//               CRC and NUM, pushes payload words to the payload FIFO for the
//               MIL-1553 transmit path and issues a one-cycle ok/err verdict
//               per packet.
//
//               Wire format:
//                 HEAD1 = {addr[7:0], size[15:8]}
//                 HEAD2 = {size[7:0], cmd[7:0]}
//                 CRC   = mod-2^16 sum of HEAD1 + HEAD2 + all data words
//                 NUM   = sender packet counter (latched, not checked)
//
// Ports       : clk, rst (active-low, async)   clock / reset
//               enable                         0 aborts to IDLE
//               in_request/in_done/in_data     pop side (RX word FIFO)
//               out_request/out_done/out_data  push side (payload FIFO)
//               rx_addr/rx_size/rx_cmd/rx_num  latched header fields
//               busy                           FSM not in IDLE
//               pkt_ok/pkt_err/err_flags       verdict, flags={size,addr,crc}
// Revision    : 1.0 - initial release
// ============================================================================
module service_protocol_receiver #(
    parameter logic [7:0]  MODULE_ADDR = 8'h01,
    parameter logic [15:0] MAX_SIZE    = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        in_request,
    input  logic        in_done,
    input  logic [15:0] in_data,
    output logic        out_request,
    input  logic        out_done,
    output logic [15:0] out_data,
    output logic [7:0]  rx_addr,
    output logic [15:0] rx_size,
    output logic [7:0]  rx_cmd,
    output logic [15:0] rx_num,
    output logic        busy,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [2:0]  err_flags
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_H1_REQ    = 4'd1;
    localparam logic [3:0] S_H1_WAIT   = 4'd2;
    localparam logic [3:0] S_H2_REQ    = 4'd3;
    localparam logic [3:0] S_H2_WAIT   = 4'd4;
    localparam logic [3:0] S_D_REQ     = 4'd5;
    localparam logic [3:0] S_D_WAIT    = 4'd6;
    localparam logic [3:0] S_PUSH_REQ  = 4'd7;
    localparam logic [3:0] S_PUSH_WAIT = 4'd8;
    localparam logic [3:0] S_CRC_REQ   = 4'd9;
    localparam logic [3:0] S_CRC_WAIT  = 4'd10;
    localparam logic [3:0] S_NUM_REQ   = 4'd11;
    localparam logic [3:0] S_NUM_WAIT  = 4'd12;
    localparam logic [3:0] S_VERDICT   = 4'd13;

    logic [3:0]  r_state;
    logic [15:0] r_crc;
    logic [15:0] r_cntr;
    logic        r_size_err;
    logic        r_addr_err;
    logic        r_crc_err;
    logic [15:0] r_num_buf;

    logic        r_in_request;
    logic        r_out_request;
    logic [15:0] r_out_data;
    logic [7:0]  r_addr;
    logic [15:0] r_size;
    logic [7:0]  r_cmd;
    logic [15:0] r_num;
    logic        r_pkt_ok;
    logic        r_pkt_err;
    logic [2:0]  r_err_flags;

    // Full size becomes known only when HEAD2 arrives: upper byte was
    // captured from HEAD1, lower byte is the top of the word being popped.
    logic [15:0] w_size;
    logic        w_size_err;
    logic        w_addr_err;
    logic [15:0] w_cntr_dec;
    logic        w_drop;

    assign w_size     = {r_size[15:8], in_data[15:8]};
    assign w_size_err = (w_size > MAX_SIZE);
    assign w_addr_err = (r_addr != MODULE_ADDR);
    assign w_cntr_dec = r_cntr - 16'd1;
    assign w_drop     = r_size_err | r_addr_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_crc         <= 16'd0;
            r_cntr        <= 16'd0;
            r_size_err    <= 1'b0;
            r_addr_err    <= 1'b0;
            r_crc_err     <= 1'b0;
            r_num_buf     <= 16'd0;
            r_in_request  <= 1'b0;
            r_out_request <= 1'b0;
            r_out_data    <= 16'd0;
            r_addr        <= 8'd0;
            r_size        <= 16'd0;
            r_cmd         <= 8'd0;
            r_num         <= 16'd0;
            r_pkt_ok      <= 1'b0;
            r_pkt_err     <= 1'b0;
            r_err_flags   <= 3'd0;
        end else begin
            // Requests and verdicts are single-cycle pulses by default.
            r_in_request  <= 1'b0;
            r_out_request <= 1'b0;
            r_pkt_ok      <= 1'b0;
            r_pkt_err     <= 1'b0;

            if (!enable) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_H1_REQ;

                    S_H1_REQ: begin
                        r_crc        <= 16'd0;
                        r_in_request <= 1'b1;
                        r_state      <= S_H1_WAIT;
                    end

                    S_H1_WAIT: if (in_done) begin
                        r_crc         <= in_data;
                        r_addr        <= in_data[15:8];
                        r_size[15:8]  <= in_data[7:0];
                        r_state       <= S_H2_REQ;
                    end

                    S_H2_REQ: begin
                        r_in_request <= 1'b1;
                        r_state      <= S_H2_WAIT;
                    end

                    S_H2_WAIT: if (in_done) begin
                        r_crc        <= r_crc + in_data;
                        r_size[7:0]  <= in_data[15:8];
                        r_cmd        <= in_data[7:0];
                        r_size_err   <= w_size_err;
                        r_addr_err   <= w_addr_err;
                        // An oversize packet carries no data phase on the
                        // wire we trust; the next word is taken as CRC.
                        r_cntr       <= w_size_err ? 16'd0 : w_size;
                        r_state      <= (w_size_err || (w_size == 16'd0)) ?
                                        S_CRC_REQ : S_D_REQ;
                    end

                    S_D_REQ: begin
                        r_in_request <= 1'b1;
                        r_state      <= S_D_WAIT;
                    end

                    S_D_WAIT: if (in_done) begin
                        r_crc  <= r_crc + in_data;
                        r_cntr <= w_cntr_dec;
                        if (w_drop) begin
                            // Keep popping to stay aligned, but push nothing.
                            r_state <= (w_cntr_dec == 16'd0) ? S_CRC_REQ : S_D_REQ;
                        end else begin
                            r_out_data <= in_data;
                            r_state    <= S_PUSH_REQ;
                        end
                    end

                    S_PUSH_REQ: begin
                        r_out_request <= 1'b1;
                        r_state       <= S_PUSH_WAIT;
                    end

                    S_PUSH_WAIT: if (out_done) begin
                        r_state <= (r_cntr == 16'd0) ? S_CRC_REQ : S_D_REQ;
                    end

                    S_CRC_REQ: begin
                        r_in_request <= 1'b1;
                        r_state      <= S_CRC_WAIT;
                    end

                    S_CRC_WAIT: if (in_done) begin
                        r_crc_err <= (in_data != r_crc);
                        r_state   <= S_NUM_REQ;
                    end

                    S_NUM_REQ: begin
                        r_in_request <= 1'b1;
                        r_state      <= S_NUM_WAIT;
                    end

                    S_NUM_WAIT: if (in_done) begin
                        r_num_buf <= in_data;
                        r_state   <= S_VERDICT;
                    end

                    S_VERDICT: begin
                        r_num       <= r_num_buf;
                        r_err_flags <= {r_size_err, r_addr_err, r_crc_err};
                        r_pkt_ok    <= ~(r_size_err | r_addr_err | r_crc_err);
                        r_pkt_err   <=  (r_size_err | r_addr_err | r_crc_err);
                        r_state     <= S_IDLE;
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign in_request  = r_in_request;
    assign out_request = r_out_request;
    assign out_data    = r_out_data;
    assign rx_addr     = r_addr;
    assign rx_size     = r_size;
    assign rx_cmd      = r_cmd;
    assign rx_num      = r_num;
    assign busy        = (r_state != S_IDLE);
    assign pkt_ok      = r_pkt_ok;
    assign pkt_err     = r_pkt_err;
    assign err_flags   = r_err_flags;

endmodule
`default_nettype wire

// File: tb/tb_service_protocol_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_service_protocol_receiver
// Description : Directed bench for service_protocol_receiver. Behavioural
//               RX FIFO and payload FIFO responders answer request pulses
//               after a programmable delay; packets are built from header
//               fields and expected results are written by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_service_protocol_receiver;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        in_request;
    logic        in_done;
    logic [15:0] in_data;
    logic        out_request;
    logic        out_done;
    logic [15:0] out_data;
    logic [7:0]  rx_addr;
    logic [15:0] rx_size;
    logic [7:0]  rx_cmd;
    logic [15:0] rx_num;
    logic        busy;
    logic        pkt_ok;
    logic        pkt_err;
    logic [2:0]  err_flags;

    service_protocol_receiver #(
        .MODULE_ADDR (8'h01),
        .MAX_SIZE    (16'd1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_request  (in_request),
        .in_done     (in_done),
        .in_data     (in_data),
        .out_request (out_request),
        .out_done    (out_done),
        .out_data    (out_data),
        .rx_addr     (rx_addr),
        .rx_size     (rx_size),
        .rx_cmd      (rx_cmd),
        .rx_num      (rx_num),
        .busy        (busy),
        .pkt_ok      (pkt_ok),
        .pkt_err     (pkt_err),
        .err_flags   (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] rx_q[$];
    logic [15:0] push_log[$];
    int          pops     = 0;
    int          rx_delay = 0;
    int          tx_delay = 0;
    bit          rnd_delay = 1'b0;
    int          ok_seen  = 0;
    int          err_seen = 0;
    logic [2:0]  last_flags = 3'd0;
    int          abort_verdicts = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] push_at(input int i);
        if (i < push_log.size()) return push_log[i];
        return 16'hxxxx;
    endfunction

    // RX word FIFO: answers each request pulse after rx_delay cycles.
    initial begin
        in_done = 1'b0;
        in_data = 16'd0;
        forever begin
            @(negedge clk);
            in_done = 1'b0;
            if (in_request) begin
                repeat (rnd_delay ? $urandom_range(0, 4) : rx_delay) @(negedge clk);
                in_data = (rx_q.size() > 0) ? rx_q.pop_front() : 16'hDEAD;
                pops++;
                in_done = 1'b1;
            end
        end
    end

    // Payload FIFO: records out_data when it completes a push.
    initial begin
        out_done = 1'b0;
        forever begin
            @(negedge clk);
            out_done = 1'b0;
            if (out_request) begin
                repeat (rnd_delay ? $urandom_range(0, 4) : tx_delay) @(negedge clk);
                push_log.push_back(out_data);
                out_done = 1'b1;
            end
        end
    end

    // Verdicts emitted while the bench expects none (abort window).
    always @(posedge clk) if (pkt_ok || pkt_err) abort_verdicts++;

    // Queue one packet; crc_xor != 0 corrupts the CRC word.
    task automatic queue_pkt(input logic [7:0] addr, input logic [15:0] size,
                             input logic [7:0] cmd, input int nd,
                             input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] crc_xor,
                             input logic [15:0] num);
        logic [15:0] h1, h2, sum;
        logic [15:0] d[3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        h1  = {addr, size[15:8]};
        h2  = {size[7:0], cmd};
        sum = h1 + h2;
        rx_q.push_back(h1);
        rx_q.push_back(h2);
        for (int i = 0; i < nd; i++) begin
            rx_q.push_back(d[i]);
            sum = sum + d[i];
        end
        rx_q.push_back(sum ^ crc_xor);
        rx_q.push_back(num);
    endtask

    task automatic clear_stats();
        pops = 0; ok_seen = 0; err_seen = 0;
        push_log.delete();
    endtask

    // Enable the receiver until n verdicts are seen or the budget expires.
    task automatic run_verdicts(input int n, input int budget);
        int seen = 0;
        enable = 1'b1;
        for (int c = 0; c < budget && seen < n; c++) begin
            @(negedge clk);
            if (pkt_ok)  ok_seen++;
            if (pkt_err) err_seen++;
            if (pkt_ok || pkt_err) begin
                seen++;
                last_flags = err_flags;
            end
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int guard;
        rst    = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {in_request, out_request, busy, pkt_ok, pkt_err}, 32'd0);
        check("rst_flags", err_flags, 32'd0);
        check("rst_addr_cmd", {rx_addr, rx_cmd}, 32'd0);
        check("rst_size", rx_size, 32'd0);
        check("rst_num_data", {rx_num, out_data}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: good packet, three payload words
        clear_stats();
        queue_pkt(8'h01, 16'd3, 8'h10, 3, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0007);
        run_verdicts(1, 200);
        check("t1_ok", ok_seen, 32'd1);
        check("t1_err", err_seen, 32'd0);
        check("t1_flags", last_flags, 32'd0);
        check("t1_npush", push_log.size(), 32'd3);
        check("t1_payload", {push_at(0), push_at(1)}, 32'h0001_0002);
        check("t1_payload2", push_at(2), 32'h0003);
        check("t1_hdr", {rx_addr, rx_cmd, rx_size}, 32'h0110_0003);
        check("t1_num", rx_num, 32'h0007);
        check("t1_pops", pops, 32'd7);
        check("t1_idle", busy, 32'd0);

        // 2: same packet, CRC off by one
        clear_stats();
        rx_delay = 2; tx_delay = 1;
        queue_pkt(8'h01, 16'd3, 8'h10, 3, 16'h0001, 16'h0002, 16'h0003, 16'h0003, 16'h0008);
        run_verdicts(1, 300);
        check("t2_err", {ok_seen[7:0], err_seen[7:0]}, 32'h0001);
        check("t2_flags", last_flags, 32'b001);
        check("t2_npush", push_log.size(), 32'd3);
        check("t2_num", rx_num, 32'h0008);

        // 3: foreign address, payload popped but dropped
        clear_stats();
        rx_delay = 0; tx_delay = 0;
        queue_pkt(8'h05, 16'd2, 8'h22, 2, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 16'h0009);
        run_verdicts(1, 200);
        check("t3_err", {ok_seen[7:0], err_seen[7:0]}, 32'h0001);
        check("t3_flags", last_flags, 32'b010);
        check("t3_npush", push_log.size(), 32'd0);
        check("t3_pops", pops, 32'd6);
        check("t3_addr", rx_addr, 32'h05);

        // 4: zero-size packet, HEAD1=0100 HEAD2=0020 CRC=0120
        clear_stats();
        queue_pkt(8'h01, 16'd0, 8'h20, 0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h000A);
        check("t4_crcword", rx_q[2], 32'h0120);
        run_verdicts(1, 200);
        check("t4_ok", {ok_seen[7:0], err_seen[7:0]}, 32'h0100);
        check("t4_pops", pops, 32'd4);
        check("t4_hdr", {rx_cmd, rx_size}, 32'h20_0000);

        // 5: oversize packet, next word is taken as CRC (which matches)
        clear_stats();
        queue_pkt(8'h01, 16'hFFFF, 8'h30, 0, 16'h0, 16'h0, 16'h0, 16'h0000, 16'h000B);
        run_verdicts(1, 200);
        check("t5_err", {ok_seen[7:0], err_seen[7:0]}, 32'h0001);
        check("t5_flags", last_flags, 32'b100);
        check("t5_pops_push", {pops[15:0], 16'(push_log.size())}, 32'h0004_0000);
        check("t5_size", rx_size, 32'hFFFF);

        // 6a: abort mid-data
        clear_stats();
        rx_delay = 2; tx_delay = 2;
        queue_pkt(8'h01, 16'd3, 8'h10, 3, 16'h0101, 16'h0202, 16'h0303, 16'h0000, 16'h000C);
        enable = 1'b1;
        guard = 0;
        while (push_log.size() < 1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("t6_first_push", push_log.size(), 32'd1);
        abort_verdicts = 0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_abort_idle", {busy, in_request, out_request}, 32'd0);
        repeat (12) @(negedge clk);
        check("t6_abort_noverdict", abort_verdicts, 32'd0);
        rx_q.delete();

        // 6b: two packets back-to-back with random done delays
        clear_stats();
        rnd_delay = 1'b1;
        queue_pkt(8'h01, 16'd3, 8'h41, 3, 16'h1111, 16'h2222, 16'h3333, 16'h0000, 16'h0010);
        queue_pkt(8'h01, 16'd2, 8'h42, 2, 16'h4444, 16'h5555, 16'h0000, 16'h0001, 16'h0011);
        run_verdicts(2, 600);
        check("t6_verdicts", {ok_seen[7:0], err_seen[7:0]}, 32'h0101);
        check("t6_flags", last_flags, 32'b001);
        check("t6_npush", push_log.size(), 32'd5);
        check("t6_payload", {push_at(3), push_at(4)}, 32'h4444_5555);
        check("t6_num", rx_num, 32'h0011);

        // 6c: asynchronous reset in the middle of a packet
        clear_stats();
        queue_pkt(8'h01, 16'd2, 8'h50, 2, 16'h0A0A, 16'h0B0B, 16'h0000, 16'h0000, 16'h0012);
        enable = 1'b1;
        guard = 0;
        while (pops < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("t6_pre_rst_addr", rx_addr, 32'h01);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_ctrl", {in_request, out_request, busy, pkt_ok, pkt_err}, 32'd0);
        check("t6_rst_fields", {rx_addr, rx_cmd, rx_size}, 32'd0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
